// File: rtl/change_request_sequencer.sv
// change_request_sequencer
//   Feeds the sparse-update block with change records read from a word memory.
//   Each record is four WORD_W words: {x}, {y}, {element hi 24}, {element lo 24}.
//   A record is presented on X/Y/NewElement with EnableChange raised until the
//   downstream block pulls EOC_Flag low (accept). The sequencer then waits for
//   EOC_Flag to return high (finished) before fetching the next record.
//   Each handshake phase is bounded by TIMEOUT cycles; expiry sets a sticky error.
//
// Ports
//   clock, reset      rising-edge clock, synchronous active-low reset
//   start             one-cycle run request (honoured only while idle)
//   base_addr         address of word 0 of record 0
//   num_req           records in the run (0 = done immediately)
//   mem_rd_en/addr    read strobe and address; mem_rdata returns one cycle later
//   X, Y, NewElement  current record
//   EnableChange      change request to downstream
//   EOC_Flag          downstream end-of-change (high = idle/finished)
//   busy, done, error run status; error is sticky until reset or next start
//   req_count         records completed in the current run
module change_request_sequencer #(
  parameter int WORD_W  = 24,
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_req,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [15:0]       X,
  output logic [15:0]       Y,
  output logic [47:0]       NewElement,
  output logic              EnableChange,
  input  logic              EOC_Flag,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  req_count
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_EOC, NEXT, FINISH} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  total;
  logic [CNT_W-1:0]  idx;
  logic [2:0]        phase;   // FETCH cycle 0..4
  logic [TMR_W-1:0]  timer;
  logic [ADDR_W-1:0] next_rec_addr;

  // Word 0 of the record after idx; the add wraps modulo 2^ADDR_W.
  assign next_rec_addr = base + ADDR_W'({idx + CNT_W'(1), 2'b00});

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      base         <= '0;
      total        <= '0;
      idx          <= '0;
      phase        <= '0;
      timer        <= '0;
      mem_rd_en    <= 1'b0;
      mem_addr     <= '0;
      X            <= '0;
      Y            <= '0;
      NewElement   <= '0;
      EnableChange <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      req_count    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            error <= 1'b0;
            busy  <= 1'b1;
            if (num_req == '0) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              base      <= base_addr;
              total     <= num_req;
              idx       <= '0;
              req_count <= '0;
              phase     <= '0;
              mem_rd_en <= 1'b1;
              mem_addr  <= base_addr;
              state     <= FETCH;
            end
          end
        end

        // Reads issue in phases 0..3; the word read in phase k arrives in
        // phase k+1, so phase 4 only captures the last word.
        FETCH: begin
          phase <= phase + 3'd1;
          if (phase < 3'd3) mem_addr  <= mem_addr + ADDR_W'(1);
          else              mem_rd_en <= 1'b0;
          case (phase)
            3'd1: X                  <= mem_rdata[15:0];
            3'd2: Y                  <= mem_rdata[15:0];
            3'd3: NewElement[47:24]  <= mem_rdata[23:0];
            3'd4: begin
              NewElement[23:0] <= mem_rdata[23:0];
              EnableChange     <= 1'b1;
              timer            <= '0;
              state            <= ISSUE;
            end
            default: ;
          endcase
        end

        // Acceptance wins over a timeout landing in the same cycle.
        ISSUE: begin
          if (!EOC_Flag) begin
            EnableChange <= 1'b0;
            timer        <= '0;
            state        <= WAIT_EOC;
          end else if (timer == TMR_LAST) begin
            EnableChange <= 1'b0;
            error        <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        WAIT_EOC: begin
          if (EOC_Flag) begin
            req_count <= req_count + CNT_W'(1);
            state     <= NEXT;
          end else if (timer == TMR_LAST) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        NEXT: begin
          idx <= idx + CNT_W'(1);
          if (idx == total - CNT_W'(1)) begin
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            phase     <= '0;
            mem_rd_en <= 1'b1;
            mem_addr  <= next_rec_addr;
            state     <= FETCH;
          end
        end

        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_request_sequencer.sv
// Bench for change_request_sequencer. Instance "a" (default TIMEOUT) is checked
// every cycle against a procedural timeline model; instance "b" (TIMEOUT=16)
// is used only for the timeout scenario with hand-computed expectations.
module tb_change_request_sequencer;
  localparam int AW = 8, CW = 6, WW = 24, TMO_A = 4096, TMO_B = 16;

  logic          clock = 1'b0, reset = 1'b0, start_a = 1'b0, start_b = 1'b0;
  logic          EOC_Flag = 1'b1;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] num_req = '0;
  logic [WW-1:0] mem_rdata = '0;

  logic a_rd, a_en, a_busy, a_done, a_err, b_rd, b_en, b_busy, b_done, b_err;
  logic [AW-1:0] a_addr, b_addr;
  logic [15:0]   a_x, a_y, b_x, b_y;
  logic [47:0]   a_ne, b_ne;
  logic [CW-1:0] a_req, b_req;

  always #5 clock = ~clock;

  change_request_sequencer #(.WORD_W(WW), .ADDR_W(AW), .CNT_W(CW), .TIMEOUT(TMO_A)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .base_addr(base_addr), .num_req(num_req),
    .mem_rd_en(a_rd), .mem_addr(a_addr), .mem_rdata(mem_rdata), .X(a_x), .Y(a_y),
    .NewElement(a_ne), .EnableChange(a_en), .EOC_Flag(EOC_Flag), .busy(a_busy),
    .done(a_done), .error(a_err), .req_count(a_req));

  change_request_sequencer #(.WORD_W(WW), .ADDR_W(AW), .CNT_W(CW), .TIMEOUT(TMO_B)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .base_addr(base_addr), .num_req(num_req),
    .mem_rd_en(b_rd), .mem_addr(b_addr), .mem_rdata(mem_rdata), .X(b_x), .Y(b_y),
    .NewElement(b_ne), .EnableChange(b_en), .EOC_Flag(EOC_Flag), .busy(b_busy),
    .done(b_done), .error(b_err), .req_count(b_req));

  // Synchronous memory, one-cycle read latency.
  logic [WW-1:0] mem [256];
  always @(posedge clock)
    if (a_rd) mem_rdata <= mem[a_addr];
    else if (b_rd) mem_rdata <= mem[b_addr];

  int n_chk = 0, n_err = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- timeline model of instance a ----------------
  logic          e_rd, e_en, e_busy, e_done, e_err;
  logic [AW-1:0] e_addr, s_base;
  logic [15:0]   e_x, e_y;
  logic [47:0]   e_ne;
  logic [CW-1:0] e_req, s_num;
  bit fetching, ab, eoc_s, st_s, chk_on;

  task automatic adv();
    @(posedge clock);
    ab = !reset; eoc_s = EOC_Flag; st_s = start_a; s_base = base_addr; s_num = num_req;
  endtask

  task automatic zero_model();
    e_rd = 0; e_addr = '0; e_x = '0; e_y = '0; e_ne = '0; e_en = 0;
    e_busy = 0; e_done = 0; e_err = 0; e_req = '0; fetching = 0;
  endtask

  task automatic run_model();
    logic [AW-1:0] b0, a;
    int n, t;
    b0 = s_base; n = int'(s_num);
    e_err = 0; e_busy = 1;
    if (n == 0) begin
      e_done = 1; adv(); if (ab) return;
      e_done = 0; e_busy = 0; return;
    end
    e_req = '0;
    for (int r = 0; r < n; r++) begin
      a = b0 + AW'(4 * r);
      fetching = 1;
      for (int k = 0; k < 4; k++) begin
        e_rd = 1; e_addr = a + AW'(k); adv(); if (ab) return;
      end
      e_rd = 0; adv(); if (ab) return;
      fetching = 0;
      e_x = mem[a][15:0]; e_y = mem[a + AW'(1)][15:0];
      e_ne = {mem[a + AW'(2)], mem[a + AW'(3)]};
      e_en = 1; t = 0;
      forever begin
        adv(); if (ab) return;
        if (!eoc_s) break;
        t++;
        if (t == TMO_A) begin e_en = 0; e_err = 1; e_busy = 0; return; end
      end
      e_en = 0; t = 0;
      forever begin
        adv(); if (ab) return;
        if (eoc_s) break;
        t++;
        if (t == TMO_A) begin e_err = 1; e_busy = 0; return; end
      end
      e_req = e_req + CW'(1);
      adv(); if (ab) return;
    end
    e_done = 1; adv(); if (ab) return;
    e_done = 0; e_busy = 0;
  endtask

  initial begin
    zero_model();
    forever begin
      adv();
      if (ab) zero_model();
      else if (st_s) begin run_model(); if (ab) zero_model(); end
    end
  end

  always @(negedge clock) if (chk_on) begin
    chk("mem_rd_en", a_rd, e_rd);
    if (e_rd) chk("mem_addr", a_addr, e_addr);
    if (!fetching) begin
      chk("X", a_x, e_x); chk("Y", a_y, e_y); chk("NewElement", a_ne, e_ne);
    end
    chk("EnableChange", a_en, e_en); chk("busy", a_busy, e_busy);
    chk("done", a_done, e_done); chk("error", a_err, e_err); chk("req_count", a_req, e_req);
  end

  // ---------------- monitors and downstream responder ----------------
  int a_en_cyc, a_win, a_done_cnt, b_en_cyc, b_done_cnt;
  logic a_en_q = 1'b0;
  logic [AW-1:0] rd_log[$];
  always @(negedge clock) begin
    if (a_en) a_en_cyc++;
    if (a_en && !a_en_q) a_win++;
    a_en_q = a_en;
    if (a_done) a_done_cnt++;
    if (a_rd) rd_log.push_back(a_addr);
    if (b_en) b_en_cyc++;
    if (b_done) b_done_cnt++;
  end

  task automatic clr_mon();
    a_en_cyc = 0; a_win = 0; a_done_cnt = 0; b_en_cyc = 0; b_done_cnt = 0; rd_log.delete();
  endtask

  // Accepts one cycle after EnableChange is seen, finishes 20 cycles later.
  bit resp_on = 0;
  initial forever begin
    @(negedge clock);
    if (resp_on && a_en && EOC_Flag) begin
      @(posedge clock); #1 EOC_Flag = 1'b0;
      repeat (20) @(posedge clock);
      #1 EOC_Flag = 1'b1;
    end
  end

  task automatic pulse(bit to_b, logic [AW-1:0] b, logic [CW-1:0] n);
    @(posedge clock); #1;
    base_addr = b; num_req = n;
    if (to_b) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic wait_done(int budget, string nm);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (a_done) break;
    end
    chk({nm, " done seen"}, a_done, 1);
  endtask

  logic [AW-1:0] wrap_exp [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 24'h000003; mem[8'h11] = 24'h000007; mem[8'h12] = 24'hABCDEF; mem[8'h13] = 24'h123456;
    mem[8'h14] = 24'h000011; mem[8'h15] = 24'h000022; mem[8'h16] = 24'h333333; mem[8'h17] = 24'h444444;
    mem[8'h18] = 24'h000055; mem[8'h19] = 24'h000066; mem[8'h1A] = 24'h777777; mem[8'h1B] = 24'h888888;
    mem[8'hFE] = 24'h1234AB; mem[8'hFF] = 24'h99BEEF; mem[8'h00] = 24'h000001; mem[8'h01] = 24'h000002;
    mem[8'h20] = 24'h000ABC; mem[8'h21] = 24'h000DEF; mem[8'h22] = 24'h010203; mem[8'h23] = 24'h040506;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst EnableChange", a_en, 0); chk("rst busy", a_busy, 0); chk("rst done", a_done, 0);
    chk("rst error", a_err, 0); chk("rst X", a_x, 0); chk("rst NewElement", a_ne, 0);
    chk("rst mem_addr", a_addr, 0); chk("rst req_count", a_req, 0); chk("rst b busy", b_busy, 0);
    chk_on = 1;
    @(posedge clock); #1 reset = 1'b1;

    // Single record
    clr_mon(); resp_on = 1;
    pulse(0, 8'h10, 6'd1);
    wait_done(200, "single");
    @(negedge clock);
    chk("single X", a_x, 16'h0003); chk("single Y", a_y, 16'h0007);
    chk("single NewElement", a_ne, 48'hABCDEF123456);
    chk("single windows", a_win, 1); chk("single en cycles", a_en_cyc, 2);
    chk("single done count", a_done_cnt, 1); chk("single req_count", a_req, 1);
    chk("single busy after", a_busy, 0);

    // Three records back-to-back
    clr_mon();
    pulse(0, 8'h10, 6'd3);
    wait_done(400, "three");
    @(negedge clock);
    chk("three reads", rd_log.size(), 12);
    for (int i = 0; i < 12 && i < rd_log.size(); i++) chk("three addr", rd_log[i], 8'h10 + i);
    chk("three windows", a_win, 3); chk("three done count", a_done_cnt, 1);
    chk("three req_count", a_req, 3); chk("three X", a_x, 16'h0055); chk("three Y", a_y, 16'h0066);
    chk("three NewElement", a_ne, 48'h777777888888);

    // Address wrap
    clr_mon();
    pulse(0, 8'hFE, 6'd1);
    wait_done(200, "wrap");
    @(negedge clock);
    chk("wrap reads", rd_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++) chk("wrap addr", rd_log[i], wrap_exp[i]);
    chk("wrap X", a_x, 16'h34AB); chk("wrap Y", a_y, 16'hBEEF);
    chk("wrap NewElement", a_ne, 48'h000001000002);

    // Timeout on the TIMEOUT=16 instance, EOC_Flag stuck high
    resp_on = 0;
    repeat (2) @(posedge clock);
    clr_mon();
    pulse(1, 8'h20, 6'd1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (b_err) break;
    end
    @(negedge clock);
    chk("timeout en cycles", b_en_cyc, 16); chk("timeout error", b_err, 1);
    chk("timeout busy", b_busy, 0); chk("timeout done count", b_done_cnt, 0);
    chk("timeout req_count", b_req, 0); chk("timeout X", b_x, 16'h0ABC);
    chk("timeout Y", b_y, 16'h0DEF); chk("timeout NewElement", b_ne, 48'h010203040506);

    // Reset during WAIT_EOC of record 2 of 3
    resp_on = 1;
    clr_mon();
    pulse(0, 8'h10, 6'd3);
    begin
      bit hit;
      hit = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clock);
        if (a_win == 2 && !a_en && a_busy) begin hit = 1; break; end
      end
      chk("midrun reached wait", hit, 1);
    end
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    chk("midrun EnableChange", a_en, 0); chk("midrun busy", a_busy, 0);
    chk("midrun X", a_x, 0); chk("midrun Y", a_y, 0); chk("midrun NewElement", a_ne, 0);
    chk("midrun mem_addr", a_addr, 0); chk("midrun mem_rd_en", a_rd, 0);
    chk("midrun req_count", a_req, 0); chk("midrun b error", b_err, 0);
    repeat (25) @(posedge clock);
    clr_mon();
    pulse(0, 8'h10, 6'd0);
    @(negedge clock);
    chk("zero done", a_done, 1); chk("zero busy", a_busy, 1);
    @(negedge clock);
    chk("zero done end", a_done, 0); chk("zero busy end", a_busy, 0);
    chk("zero reads", rd_log.size(), 0);

    // Upper bits discarded, start while busy ignored
    mem[8'h40] = 24'hFF0005; mem[8'h41] = 24'hAA0009; mem[8'h42] = 24'h111111; mem[8'h43] = 24'h222222;
    clr_mon();
    pulse(0, 8'h40, 6'd1);
    repeat (2) @(posedge clock);
    pulse(0, 8'h80, 6'd2);
    wait_done(200, "busy start");
    @(negedge clock);
    chk("upper X", a_x, 16'h0005); chk("upper Y", a_y, 16'h0009);
    chk("busy start reads", rd_log.size(), 4);
    if (rd_log.size() > 0) chk("busy start first addr", rd_log[0], 8'h40);
    chk("busy start req_count", a_req, 1);
    repeat (40) @(negedge clock);
    chk("busy start idle", a_busy, 0); chk("busy start done count", a_done_cnt, 1);
    chk("busy start reads later", rd_log.size(), 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
